// File: rtl/button_conditioner.sv
// Per-channel push-button conditioner: two-flop synchroniser, counter debouncer,
// registered press/release pulses and an optional hold-to-repeat fire generator.
module button_conditioner #(
  parameter int unsigned  N             = 3,
  parameter int unsigned  STABLE_CYCLES = 4,
  parameter int unsigned  REPEAT_DELAY  = 50_000_000,
  parameter int unsigned  REPEAT_PERIOD = 10_000_000,
  parameter logic [N-1:0] REPEAT_MASK   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  // 'release' is a reserved word, hence the suffix.
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] fire
);

  localparam int unsigned DW   = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic          s1, s2;
    logic          lvl, prs, rls, fr;
    logic [DW-1:0] dcnt, dcnt_inc;
    logic [RW-1:0] rcnt, rcnt_inc;
    logic [1:0]    state;
    logic          flip, rise, fall;

    always_comb begin
      dcnt_inc = dcnt + DW'(1);
      rcnt_inc = rcnt + RW'(1);
      flip     = (s2 != lvl) && (dcnt_inc == DW'(STABLE_CYCLES));
      rise     = flip && !lvl;
      fall     = flip && lvl;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        prs   <= 1'b0;
        rls   <= 1'b0;
        fr    <= 1'b0;
        dcnt  <= '0;
        rcnt  <= '0;
        state <= StIdle;
      end else begin
        s1 <= btn_in[i];
        s2 <= s1;

        if (s2 == lvl) begin
          dcnt <= '0;
        end else if (flip) begin
          dcnt <= '0;
          lvl  <= ~lvl;
        end else begin
          dcnt <= dcnt_inc;
        end

        prs <= rise;
        rls <= fall;
        fr  <= 1'b0;

        // A release wins over any timer match on the same edge.
        if (fall) begin
          state <= StIdle;
          rcnt  <= '0;
        end else begin
          case (state)
            StIdle: begin
              if (rise) begin
                fr <= 1'b1;
                if (REPEAT_MASK[i]) begin
                  state <= StWait;
                  rcnt  <= RW'(1);
                end
              end
            end
            StWait: begin
              if (rcnt == RW'(REPEAT_DELAY)) begin
                fr    <= 1'b1;
                rcnt  <= RW'(1);
                state <= StRepeat;
              end else begin
                rcnt <= rcnt_inc;
              end
            end
            StRepeat: begin
              if (rcnt == RW'(REPEAT_PERIOD)) begin
                fr   <= 1'b1;
                rcnt <= RW'(1);
              end else begin
                rcnt <= rcnt_inc;
              end
            end
            default: begin
              state <= StIdle;
              rcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign level[i]         = lvl;
    assign press[i]         = prs;
    assign release_pulse[i] = rls;
    assign fire[i]          = fr;
  end

endmodule
